// File: rtl/store_merge_unit_if.sv
// Request/response bundle for store_merge_unit: store request, memory strobes and merged data.
// master = requester/memory side, slave = the merge unit.
interface store_merge_unit_if;
    logic        start;
    logic [1:0]  ss_mode;
    logic [1:0]  addr_low;
    logic [31:0] reg_data;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] out_data;
    logic        data_src_sel;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, ss_mode, addr_low, reg_data, mem_rdata,
        input  mem_rd, mem_wr, out_data, data_src_sel, busy, done, err
    );

    modport slave (
        input  start, ss_mode, addr_low, reg_data, mem_rdata,
        output mem_rd, mem_wr, out_data, data_src_sel, busy, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Sub-word store merge: read-modify-write of a memory word for SB/SH, direct write for SW.
// Illegal sizes or misaligned halves are rejected with a one-cycle err pulse.
module store_merge_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    store_merge_unit_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StMerge = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;
    localparam logic [2:0] StFail  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic [31:0] merged;

    always_comb begin
        merged = word_q;
        case (mode_q)
            2'b00: merged = data_q;
            2'b01: begin
                if (addr_q[1]) merged[31:16] = data_q[15:0];
                else           merged[15:0]  = data_q[15:0];
            end
            2'b10:   merged[{addr_q, 3'b000} +: 8] = data_q[7:0];
            default: merged = word_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_d = bus.ss_mode;
                    addr_d = bus.addr_low;
                    data_d = bus.reg_data;
                    if (bus.ss_mode == 2'b11 || (bus.ss_mode == 2'b01 && bus.addr_low[0]))
                        state_d = StFail;
                    else if (bus.ss_mode == 2'b00)
                        state_d = StMerge;
                    else
                        state_d = StRead;
                end
            end
            StRead: begin
                cnt_d   = 3'(MEM_LATENCY - 1);
                state_d = StWait;
            end
            StWait: begin
                // Read data is valid on the final wait cycle only.
                if (cnt_q == 3'd0) begin
                    word_d  = bus.mem_rdata;
                    state_d = StMerge;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StMerge: begin
                out_d   = merged;
                state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= 2'b00;
            addr_q  <= 2'b00;
            data_q  <= 32'h0;
            word_q  <= 32'h0;
            cnt_q   <= 3'd0;
            out_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.mem_rd       = (state_q == StRead);
    assign bus.mem_wr       = (state_q == StWrite);
    assign bus.data_src_sel = (state_q == StWrite);
    assign bus.done         = (state_q == StWrite);
    assign bus.err          = (state_q == StFail);
    assign bus.busy         = (state_q != StIdle);
    assign bus.out_data     = out_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: directed stores push expected writes/errors,
// a negedge monitor pops and compares whenever the DUT writes or flags an error.
module tb_store_merge_unit;

    localparam int unsigned MemLatency = 1;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    store_merge_unit_if bus ();

    store_merge_unit #(.MEM_LATENCY(MemLatency)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    logic [31:0] mem_word = 32'h0;
    logic [3:0]  rd_hist  = 4'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_hist <= {rd_hist[2:0], bus.mem_rd};
    end

    // Memory returns the word only in the cycle MemLatency after the read strobe.
    assign bus.mem_rdata = rd_hist[MemLatency-1] ? mem_word : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per mem_wr or err presented by the DUT.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            if (bus.mem_rd) rd_cnt++;
            if (bus.mem_rd || bus.mem_wr)
                check("rd_wr_exclusive", {31'b0, bus.mem_rd & bus.mem_wr}, 32'h0);
            if (bus.mem_wr || bus.err) begin
                if (bus.mem_wr) wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: wr=%0b err=%0b with no pending store",
                             bus.mem_wr, bus.err);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {31'b0, bus.err}, {31'b0, e.is_err});
                    check("resp_latency", cyc, e.cyc);
                    if (!e.is_err) begin
                        check("out_data", bus.out_data, e.data);
                        check("done_sel", {30'b0, bus.done, bus.data_src_sel}, 32'h3);
                    end else begin
                        check("err_no_mem", {30'b0, bus.mem_rd, bus.mem_wr}, 32'h0);
                    end
                end
            end
        end
    end

    // Called at a negedge; drives start for one cycle then scrambles the request inputs.
    task automatic issue(input logic [1:0] mode, input logic [1:0] al, input logic [31:0] data,
                         input logic [31:0] mem, input bit push, input bit is_err,
                         input logic [31:0] exp_data);
        exp_t e;
        mem_word     = mem;
        bus.start    = 1'b1;
        bus.ss_mode  = mode;
        bus.addr_low = al;
        bus.reg_data = data;
        if (push) begin
            e.is_err = is_err;
            e.data   = exp_data;
            e.cyc    = cyc + (is_err ? 1 : (mode == 2'b00 ? 2 : 3 + int'(MemLatency)));
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.ss_mode  = 2'($urandom);
        bus.addr_low = 2'($urandom);
        bus.reg_data = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0b expected 0", bus.busy);
        end
    endtask

    task automatic store(input logic [1:0] mode, input logic [1:0] al, input logic [31:0] data,
                         input logic [31:0] mem, input logic [31:0] exp_data,
                         input int exp_rd);
        int rd0 = rd_cnt;
        issue(mode, al, data, mem, 1'b1, 1'b0, exp_data);
        wait_idle();
        @(negedge clk);
        check("mem_rd_pulses", rd_cnt - rd0, exp_rd);
    endtask

    initial begin
        int wr0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.ss_mode  = 2'b00;
        bus.addr_low = 2'b00;
        bus.reg_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.mem_rd, bus.mem_wr, bus.data_src_sel, bus.busy, bus.done,
                                bus.err, 26'b0} | bus.out_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        store(2'b00, 2'd2, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0);
        store(2'b10, 2'd2, 32'h000000AB, 32'h11223344, 32'h11AB3344, 1);
        store(2'b01, 2'd2, 32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 1);
        store(2'b10, 2'd0, 32'h12345655, 32'hAABBCCDD, 32'hAABBCC55, 1);
        store(2'b01, 2'd0, 32'hFFFF1234, 32'hAABBCCDD, 32'hAABB1234, 1);
        store(2'b10, 2'd3, 32'h00000099, 32'h11223344, 32'h99223344, 1);
        check("out_hold_idle", bus.out_data, 32'h99223344);

        // Illegal requests: misaligned half and mode 11.
        issue(2'b01, 2'd1, 32'h5555AAAA, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("fail_busy_low", {31'b0, bus.busy}, 32'h0);
        issue(2'b11, 2'd0, 32'h5555AAAA, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("fail_busy_low", {31'b0, bus.busy}, 32'h0);
        check("out_hold_fail", bus.out_data, 32'h99223344);

        // Second start during WAIT is dropped.
        wr0 = wr_cnt;
        issue(2'b10, 2'd1, 32'h000000EE, 32'h11223344, 1'b1, 1'b0, 32'h1122EE44);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.ss_mode  = 2'b00;
        bus.reg_data = 32'hFFFFFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("single_write", wr_cnt - wr0, 1);

        // Reset during WAIT aborts the store; a word store right after reset completes.
        wr0 = wr_cnt;
        issue(2'b10, 2'd0, 32'h00000077, 32'h11223344, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outputs", {bus.mem_rd, bus.mem_wr, bus.data_src_sel, bus.busy, bus.done,
                                bus.err, 26'b0} | bus.out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        store(2'b00, 2'd1, 32'hC0FFEE01, 32'h0, 32'hC0FFEE01, 0);
        repeat (3) @(negedge clk);
        check("post_reset_writes", wr_cnt - wr0, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, giving the memory read latency in cycles (legal range 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle store request, sampled only in IDLE.
REQ-005 SHALL have port ss_mode, input, 2: store size, 00 word (SW), 01 half (SH), 10 byte (SB), 11 illegal.
REQ-006 SHALL have port addr_low, input, 2: byte offset of the store address, bits [1:0].
REQ-007 SHALL have port reg_data, input, 32: source register value (B register).
REQ-008 SHALL have port mem_rdata, input, 32: memory read data, valid MEM_LATENCY cycles after the mem_rd cycle.
REQ-009 SHALL have port mem_rd, output, 1: memory read strobe for the read-modify-write.
REQ-010 SHALL have port mem_wr, output, 1: memory write strobe.
REQ-011 SHALL have port out_data, output, 32: merged store word, fed to the size_handler leg of the data-source mux.
REQ-012 SHALL have port data_src_sel, output, 1: 1 while out_data is the word to be written, else 0.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on completion of a store.
REQ-015 SHALL have port err, output, 1: one-cycle pulse on a rejected store.

Function
REQ-016 SHALL implement the states IDLE, READ, WAIT, MERGE, WRITE and FAIL.
REQ-017 SHALL, in IDLE on start=1, latch ss_mode, addr_low and reg_data, then branch as follows:
- Illegal request (mode 11, or mode 01 with addr_low[0]=1): go to FAIL.
- Word mode: go to MERGE.
- Otherwise: go to READ.
REQ-018 SHALL hold mem_rd=1 for exactly the one READ cycle, then go to WAIT.
REQ-019 SHALL stay in WAIT for MEM_LATENCY cycles, capture mem_rdata on the last WAIT cycle, then go to MERGE.
REQ-020 SHALL, in MERGE, register out_data as follows (byte lane k = bits [8k+7:8k], little-endian):
- Word: the latched reg_data.
- Half: the captured word with lanes {addr_low[1]*2, +1} replaced by reg_data[15:0].
- Byte: the captured word with lane addr_low replaced by reg_data[7:0].
REQ-021 SHALL, in WRITE, assert mem_wr=1, data_src_sel=1 and done=1 for one cycle, hold out_data stable, then return to IDLE.
REQ-022 SHALL, in FAIL, assert err=1 for one cycle with no mem_rd or mem_wr, then return to IDLE.
REQ-023 SHALL ignore start while busy=1; no request is queued.
REQ-024 SHALL ignore changes on reg_data, ss_mode and addr_low after the start cycle.
REQ-025 SHALL hold out_data at its last value outside MERGE and WRITE; data_src_sel=0 outside WRITE.
REQ-026 SHALL give these latencies from the start cycle to the WRITE cycle:
- Word: 2 cycles.
- Half/byte: 3+MEM_LATENCY cycles.
REQ-027 SHALL never assert mem_rd and mem_wr in the same cycle.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, out_data=32'h0 and mem_rd=mem_wr=data_src_sel=busy=done=err=0.
REQ-029 SHALL abort an in-flight store when reset asserts in any state: no mem_wr issued, latched data discarded.
REQ-030 SHALL accept start on the first clock edge after reset deasserts.

Verification
REQ-031 SHALL be tested with SW: reg_data=32'hDEADBEEF, addr_low=2 -> no mem_rd; out_data=32'hDEADBEEF with mem_wr=1 two cycles after start.
REQ-032 SHALL be tested with SB: reg_data=32'h000000AB, addr_low=2, mem_rdata=32'h11223344, MEM_LATENCY=1 -> one mem_rd pulse; out_data=32'h11AB3344 with mem_wr=1 and done=1 four cycles after start.
REQ-033 SHALL be tested with SH: reg_data=32'h0000CAFE, addr_low=2, mem_rdata=32'h11223344 -> out_data=32'hCAFE3344.
REQ-034 SHALL be tested with illegal requests: SH with addr_low=1, and ss_mode=11 -> err pulse one cycle after start; mem_rd=mem_wr=0 throughout; busy low after 2 cycles.
REQ-035 SHALL be tested with a second start pulsed during WAIT -> ignored; exactly one mem_wr occurs.
REQ-036 SHALL be tested with reset asserted during WAIT -> all outputs 0 immediately; no mem_wr follows; a new SW completes normally afterwards.
